// File: rtl/boot_sequencer_if.sv
// Board-side signal bundle of the boot sequencer.
// Inputs : btn_rst_i, sw_fetch_en_i (raw, asynchronous), vio_reset_i,
//          vio_fetch_en_i, soc_status_i (clk_i domain)
// Outputs: soc_rst_no, soc_fetch_en_o, done_o, timeout_o, state_o[2:0]
// The sequencer uses the slave modport; whoever drives the pins uses master.
interface boot_sequencer_if;
  logic       btn_rst_i;
  logic       sw_fetch_en_i;
  logic       vio_reset_i;
  logic       vio_fetch_en_i;
  logic       soc_status_i;
  logic       soc_rst_no;
  logic       soc_fetch_en_o;
  logic       done_o;
  logic       timeout_o;
  logic [2:0] state_o;

  modport master (
    output btn_rst_i, sw_fetch_en_i, vio_reset_i, vio_fetch_en_i, soc_status_i,
    input  soc_rst_no, soc_fetch_en_o, done_o, timeout_o, state_o
  );

  modport slave (
    input  btn_rst_i, sw_fetch_en_i, vio_reset_i, vio_fetch_en_i, soc_status_i,
    output soc_rst_no, soc_fetch_en_o, done_o, timeout_o, state_o
  );
endinterface

// File: rtl/boot_sequencer.sv
// Board-level reset/boot controller for the SoC wrapper (soc_clk domain).
// Debounces the reset button and fetch switch, holds the SoC in reset for a
// minimum time, waits a settle period, then enables fetch and watches the
// SoC status line for completion or timeout.
// Ports: clk_i, rst_ni (async active-low) and the board bundle `bus`
//        (boot_sequencer_if.slave); all bus outputs are flops.
module boot_sequencer #(
  parameter int unsigned DebounceCycles   = 20000,
  parameter int unsigned ResetHoldCycles  = 1024,
  parameter int unsigned FetchDelayCycles = 64,
  parameter int unsigned TimeoutCycles    = 32'd16777216
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  boot_sequencer_if.slave  bus
);

  localparam int unsigned CntW = 32;
  localparam int unsigned DbW  = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam int unsigned NIn  = 2;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_IDLE    = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  // Raw inputs: bit 0 = reset button, bit 1 = fetch switch
  logic [NIn-1:0] w_raw;
  logic [NIn-1:0] r_sync1;
  logic [NIn-1:0] r_sync2;
  logic [NIn-1:0] r_deb;
  logic [DbW-1:0] r_db_cnt [NIn];

  logic           w_rst_req;
  logic           w_fetch_req;

  state_e         r_state;
  state_e         w_state_next;
  logic [CntW-1:0] r_cnt;

  logic           r_soc_rst_n;
  logic           r_fetch_en;
  logic           r_done;
  logic           r_timeout;
  logic           w_soc_rst_n_next;
  logic           w_fetch_en_next;
  logic           w_done_next;
  logic           w_timeout_next;

  assign w_raw = {bus.sw_fetch_en_i, bus.btn_rst_i};

  // Two-flop synchroniser followed by a stable-count debouncer per input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < NIn; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NIn; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DbW'(DebounceCycles - 1)) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DbW'(1);
        end
      end
    end
  end

  assign w_rst_req   = r_deb[0] | bus.vio_reset_i;
  assign w_fetch_req = r_deb[1] | bus.vio_fetch_en_i;

  // Next-state decode and registered-output decode
  always_comb begin
    w_state_next     = r_state;
    w_soc_rst_n_next = 1'b0;
    w_fetch_en_next  = 1'b0;
    w_done_next      = 1'b0;
    w_timeout_next   = 1'b0;

    // A reset request outside HOLD wins over every other transition
    if (w_rst_req && (r_state != ST_HOLD)) begin
      w_state_next = ST_HOLD;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (!w_rst_req && (r_cnt >= CntW'(ResetHoldCycles - 1))) w_state_next = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_cnt == CntW'(FetchDelayCycles - 1)) w_state_next = ST_IDLE;
        end
        ST_IDLE: begin
          if (w_fetch_req) w_state_next = ST_RUN;
        end
        ST_RUN: begin
          if (bus.soc_status_i) begin
            w_state_next = ST_DONE;
          end else if ((TimeoutCycles != 0) && (r_cnt == CntW'(TimeoutCycles - 1))) begin
            w_state_next = ST_TIMEOUT;
          end else if (!w_fetch_req) begin
            w_state_next = ST_IDLE;
          end
        end
        ST_DONE: begin
          w_state_next = ST_DONE;
        end
        ST_TIMEOUT: begin
          if (bus.soc_status_i) w_state_next = ST_DONE;
        end
        default: begin
          w_state_next = ST_HOLD;
        end
      endcase
    end

    w_soc_rst_n_next = (w_state_next != ST_HOLD);
    w_fetch_en_next  = (w_state_next == ST_RUN) || (w_state_next == ST_DONE) ||
                       (w_state_next == ST_TIMEOUT);
    w_done_next      = (w_state_next == ST_DONE);
    w_timeout_next   = (w_state_next == ST_TIMEOUT);
  end

  // State, shared cycle counter and output flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_soc_rst_n <= 1'b0;
      r_fetch_en  <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_soc_rst_n <= w_soc_rst_n_next;
      r_fetch_en  <= w_fetch_en_next;
      r_done      <= w_done_next;
      r_timeout   <= w_timeout_next;
      // Counter restarts on any state change and saturates otherwise
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign bus.soc_rst_no     = r_soc_rst_n;
  assign bus.soc_fetch_en_o = r_fetch_en;
  assign bus.done_o         = r_done;
  assign bus.timeout_o      = r_timeout;
  assign bus.state_o        = r_state;

endmodule

// File: tb/tb_boot_sequencer.sv
`timescale 1ns/1ps
module tb_boot_sequencer;

  localparam int DB     = 4;
  localparam int HOLD_N = 8;
  localparam int DLY_N  = 4;
  localparam int TO_N   = 32;

  localparam int M_HOLD = 0, M_SETTLE = 1, M_IDLE = 2, M_RUN = 3, M_DONE = 4, M_TIMEOUT = 5;
  localparam int NVEC = 27;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  boot_sequencer_if bus ();

  boot_sequencer #(
    .DebounceCycles  (DB),
    .ResetHoldCycles (HOLD_N),
    .FetchDelayCycles(DLY_N),
    .TimeoutCycles   (TO_N)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       vio_rst;
    logic       vio_fetch;
    logic       status;
    int         n;
    logic [2:0] st;
  } vec_t;

  vec_t tbl [NVEC];

  // Expected output vector {state, rst_n, fetch_en, done, timeout} for a state
  function automatic logic [6:0] pk(input int st);
    logic [2:0] s;
    s = 3'(st);
    return {s, (st != M_HOLD),
            (st == M_RUN || st == M_DONE || st == M_TIMEOUT),
            (st == M_DONE), (st == M_TIMEOUT)};
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {bus.state_o, bus.soc_rst_no, bus.soc_fetch_en_o, bus.done_o, bus.timeout_o};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d rst_n=%b fen=%b done=%b to=%b, want st=%0d rst_n=%b fen=%b done=%b to=%b",
               name, got[6:4], got[3], got[2], got[1], got[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Reference model: raw histories as shift vectors, time-in-state from timestamps
  int         m_state, m_edge, m_entry, m_age, m_nxt;
  logic [7:0] m_raw_b, m_raw_s, m_hist_b, m_hist_s;
  logic       m_deb_b, m_deb_s, m_sb, m_ss, m_rq, m_fq;

  // True when the last DB synchronised samples all disagree with the debounced value
  function automatic logic all_differ(input logic [7:0] h, input logic d);
    for (int i = 0; i < DB; i++) if (h[i] == d) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_state = M_HOLD; m_edge = 0; m_entry = 0;
      m_raw_b = '0; m_raw_s = '0; m_hist_b = '0; m_hist_s = '0;
      m_deb_b = 1'b0; m_deb_s = 1'b0;
    end else begin
      // Synchronised value is the raw sample from two edges ago
      m_sb = m_raw_b[1];
      m_ss = m_raw_s[1];
      m_raw_b = {m_raw_b[6:0], bus.btn_rst_i};
      m_raw_s = {m_raw_s[6:0], bus.sw_fetch_en_i};
      m_rq = m_deb_b | bus.vio_reset_i;
      m_fq = m_deb_s | bus.vio_fetch_en_i;
      m_hist_b = {m_hist_b[6:0], m_sb};
      m_hist_s = {m_hist_s[6:0], m_ss};
      if (all_differ(m_hist_b, m_deb_b)) m_deb_b = ~m_deb_b;
      if (all_differ(m_hist_s, m_deb_s)) m_deb_s = ~m_deb_s;

      m_age = m_edge - m_entry;
      m_nxt = m_state;
      if (m_rq && m_state != M_HOLD) m_nxt = M_HOLD;
      else begin
        case (m_state)
          M_HOLD:    if (!m_rq && m_age >= HOLD_N - 1) m_nxt = M_SETTLE;
          M_SETTLE:  if (m_age == DLY_N - 1) m_nxt = M_IDLE;
          M_IDLE:    if (m_fq) m_nxt = M_RUN;
          M_RUN: begin
            if (bus.soc_status_i) m_nxt = M_DONE;
            else if (m_age == TO_N - 1) m_nxt = M_TIMEOUT;
            else if (!m_fq) m_nxt = M_IDLE;
          end
          M_TIMEOUT: if (bus.soc_status_i) m_nxt = M_DONE;
          default: ;
        endcase
      end
      if (m_nxt != m_state) m_entry = m_edge + 1;
      m_state = m_nxt;
      m_edge++;
    end
  end

  task automatic setv(input int i, input logic vr, input logic vf, input logic st, input int n,
                      input int exp_st);
    tbl[i].vio_rst = vr; tbl[i].vio_fetch = vf; tbl[i].status = st;
    tbl[i].n = n; tbl[i].st = 3'(exp_st);
  endtask

  initial begin
    logic b, s, vr, vf, st;

    // Boot, done, timeout, reset-vs-status collision, fetch drop
    setv( 0, 0, 0, 0,  7, M_HOLD);
    setv( 1, 0, 0, 0,  1, M_SETTLE);
    setv( 2, 0, 0, 0,  3, M_SETTLE);
    setv( 3, 0, 0, 0,  1, M_IDLE);
    setv( 4, 0, 0, 0,  5, M_IDLE);
    setv( 5, 0, 1, 0,  1, M_RUN);
    setv( 6, 0, 1, 0,  9, M_RUN);
    setv( 7, 0, 1, 1,  1, M_DONE);
    setv( 8, 0, 0, 0,  3, M_DONE);
    setv( 9, 1, 0, 0,  1, M_HOLD);
    setv(10, 0, 1, 0,  8, M_SETTLE);
    setv(11, 0, 1, 0,  4, M_IDLE);
    setv(12, 0, 1, 0,  1, M_RUN);
    setv(13, 0, 1, 0, 31, M_RUN);
    setv(14, 0, 1, 0,  1, M_TIMEOUT);
    setv(15, 0, 1, 1,  1, M_DONE);
    setv(16, 1, 1, 0,  1, M_HOLD);
    setv(17, 0, 1, 0,  8, M_SETTLE);
    setv(18, 0, 1, 0,  4, M_IDLE);
    setv(19, 0, 1, 0,  1, M_RUN);
    setv(20, 0, 1, 0, 31, M_RUN);
    setv(21, 1, 1, 1,  1, M_HOLD);
    setv(22, 0, 1, 0,  8, M_SETTLE);
    setv(23, 0, 1, 0,  4, M_IDLE);
    setv(24, 0, 1, 0,  1, M_RUN);
    setv(25, 0, 0, 0,  1, M_IDLE);
    setv(26, 0, 0, 0,  3, M_IDLE);

    bus.btn_rst_i = 1'b0; bus.sw_fetch_en_i = 1'b0;
    bus.vio_reset_i = 1'b0; bus.vio_fetch_en_i = 1'b0; bus.soc_status_i = 1'b0;

    #12;
    check("reset", pk(M_HOLD));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      bus.vio_reset_i    = tbl[i].vio_rst;
      bus.vio_fetch_en_i = tbl[i].vio_fetch;
      bus.soc_status_i   = tbl[i].status;
      tick(tbl[i].n);
      check($sformatf("vec%0d", i), pk(int'(tbl[i].st)));
    end

    // Short button bounces never reach the debounced reset
    for (int p = 0; p < 3; p++) begin
      bus.btn_rst_i = 1'b1; tick(3); check($sformatf("bounce_hi%0d", p), pk(M_IDLE));
      bus.btn_rst_i = 1'b0; tick(3); check($sformatf("bounce_lo%0d", p), pk(M_IDLE));
    end
    tick(6);
    check("bounce_settled", pk(M_IDLE));

    // Held press: HOLD on the 7th edge, extended until the release is debounced
    bus.btn_rst_i = 1'b1;
    tick(6); check("press_pre", pk(M_IDLE));
    tick(1); check("press_hold", pk(M_HOLD));
    tick(3);
    bus.btn_rst_i = 1'b0;
    tick(6); check("release_hold", pk(M_HOLD));
    tick(1); check("release_settle", pk(M_SETTLE));

    // Asynchronous reset in the middle of SETTLE
    tick(1); check("settle_pre", pk(M_SETTLE));
    #2 rst_ni = 1'b0;
    #1 check("async_reset", pk(M_HOLD));
    tick(2); check("reset_held", pk(M_HOLD));
    rst_ni = 1'b1;

    // Randomised traffic against the reference model
    b = 1'b0; s = 1'b0; vf = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) b = ~b;
      if ($urandom_range(0, 15) == 0) s = ~s;
      if ($urandom_range(0, 24) == 0) vf = ~vf;
      vr = ($urandom_range(0, 149) == 0);
      st = ($urandom_range(0, 49) == 0);
      bus.btn_rst_i = b; bus.sw_fetch_en_i = s;
      bus.vio_reset_i = vr; bus.vio_fetch_en_i = vf; bus.soc_status_i = st;
      if (c == 1500) begin
        rst_ni = 1'b0;
        #2 rst_ni = 1'b1;
      end
      tick(1);
      check($sformatf("rand%0d", c), pk(m_state));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
